// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic datapath (16x16 multiplier and 32/16 divider).
// Holds the default operand widths and the divider FSM state encoding.
package arith_pkg;

    localparam int DEF_DIVIDEND_W = 32;
    localparam int DEF_DIVISOR_W  = 16;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: compare the trial value against the divisor and subtract when it fits.
// Purely combinational; the caller supplies {partial remainder, next dividend bit}.
module div_step
    import arith_pkg::*;
#(
    parameter int DIVISOR_W = DEF_DIVISOR_W
) (
    input  logic [DIVISOR_W:0]   trial,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] new_rem,
    output logic                 q_bit
);

    logic [DIVISOR_W-1:0] diff_s;

    // The true difference is always below 2**DIVISOR_W, so modular subtraction of the low bits is exact.
    assign diff_s = trial[DIVISOR_W-1:0] - divisor;

    // Restore (keep the trial) when the divisor does not fit, otherwise take the difference.
    always_comb begin
        if (trial >= {1'b0, divisor}) begin
            new_rem = diff_s;
            q_bit   = 1'b1;
        end else begin
            new_rem = trial[DIVISOR_W-1:0];
            q_bit   = 1'b0;
        end
    end

endmodule

// File: rtl/seq_divider_32by16.sv
// Multi-cycle restoring unsigned divider retiring one quotient bit per clock,
// with valid/ready handshakes on the operand and result sides.
module seq_divider_32by16
    import arith_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int                CNT_W    = $clog2(DIVIDEND_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIVIDEND_W - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]            state_r,     state_s;
    logic [CNT_W-1:0]      count_r,     count_s;
    logic [DIVIDEND_W-1:0] dq_r,        dq_s;
    logic [DIVISOR_W-1:0]  dvs_r,       dvs_s;
    logic [DIVISOR_W-1:0]  rem_r,       rem_s;
    logic [DIVIDEND_W-1:0] quotient_r,  quotient_s;
    logic [DIVISOR_W-1:0]  remainder_r, remainder_s;
    logic                  dbz_r,       dbz_s;
    logic                  in_ready_r,  in_ready_s;
    logic                  out_valid_r, out_valid_s;

    logic [DIVISOR_W:0]    trial_s;
    logic [DIVISOR_W-1:0]  step_rem_s;
    logic                  step_q_s;
    logic                  accept_s;
    logic                  retire_s;

    // dq_r shifts left each step: its MSB feeds the next dividend bit while quotient bits
    // enter at the LSB, so after DIVIDEND_W steps it holds the complete quotient.
    assign trial_s  = {rem_r, dq_r[DIVIDEND_W-1]};
    assign accept_s = in_valid && in_ready_r;
    assign retire_s = out_valid_r && out_ready;

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_div_step (
        .trial   (trial_s),
        .divisor (dvs_r),
        .new_rem (step_rem_s),
        .q_bit   (step_q_s)
    );

    // Next-state and datapath update for the IDLE/CALC/DONE sequence.
    always_comb begin
        state_s     = state_r;
        count_s     = count_r;
        dq_s        = dq_r;
        dvs_s       = dvs_r;
        rem_s       = rem_r;
        quotient_s  = quotient_r;
        remainder_s = remainder_r;
        dbz_s       = dbz_r;
        in_ready_s  = in_ready_r;
        out_valid_s = out_valid_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    dq_s       = dividend;
                    dvs_s      = divisor;
                    rem_s      = {DIVISOR_W{1'b0}};
                    count_s    = CNT_LAST;
                    in_ready_s = 1'b0;
                    if (divisor == {DIVISOR_W{1'b0}}) begin
                        // out_valid rises one cycle later from DONE.
                        state_s     = DONE;
                        quotient_s  = {DIVIDEND_W{1'b1}};
                        remainder_s = dividend[DIVISOR_W-1:0];
                        dbz_s       = 1'b1;
                    end else begin
                        state_s = CALC;
                    end
                end else begin
                    in_ready_s = 1'b1;
                end
            end
            CALC: begin
                rem_s = step_rem_s;
                dq_s  = {dq_r[DIVIDEND_W-2:0], step_q_s};
                if (count_r == {CNT_W{1'b0}}) begin
                    state_s     = DONE;
                    out_valid_s = 1'b1;
                    quotient_s  = {dq_r[DIVIDEND_W-2:0], step_q_s};
                    remainder_s = step_rem_s;
                    dbz_s       = 1'b0;
                end else begin
                    count_s = count_r - CNT_ONE;
                end
            end
            DONE: begin
                if (retire_s) begin
                    state_s     = IDLE;
                    out_valid_s = 1'b0;
                    in_ready_s  = 1'b1;
                end else begin
                    out_valid_s = 1'b1;
                end
            end
            default: begin
                state_s     = IDLE;
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // State and result registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            count_r     <= {CNT_W{1'b0}};
            dq_r        <= {DIVIDEND_W{1'b0}};
            dvs_r       <= {DIVISOR_W{1'b0}};
            rem_r       <= {DIVISOR_W{1'b0}};
            quotient_r  <= {DIVIDEND_W{1'b0}};
            remainder_r <= {DIVISOR_W{1'b0}};
            dbz_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            count_r     <= count_s;
            dq_r        <= dq_s;
            dvs_r       <= dvs_s;
            rem_r       <= rem_s;
            quotient_r  <= quotient_s;
            remainder_r <= remainder_s;
            dbz_r       <= dbz_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

endmodule
